conv_upsample_2x_stream: RTL

Nearest-neighbour 2x upsampler for the decoder path. It is the inverse of the stride-2 decimation done in the encoder's 1x1 stride-2 convolutions. It consumes one channel plane as a raster stream of IMAGE_WIDTH x IMAGE_HEIGHT pixels and emits a 2*IMAGE_WIDTH x 2*IMAGE_HEIGHT raster stream:
- each pixel is repeated twice horizontally;
- each row is repeated twice vertically, replayed from an internal line buffer.

It sits between a reduced-resolution feature stream and the next convolution's `valid_in`/`pxl_in` inputs.

---
 rtl/conv_upsample_2x_stream.sv | 136 +++++++++++++
 1 files changed

// File: rtl/conv_upsample_2x_stream.sv
// Nearest-neighbour 2x upsampler for one channel plane.
// Each input pixel is emitted twice (ROW_A, straight from the input), then the
// whole row is replayed twice-per-pixel from a line buffer (ROW_B), so every
// input row becomes two output rows of 2*IMAGE_WIDTH words.
//
// Handshake: the upstream side offers a pixel with valid_in; it is accepted on
// a rising edge where valid_in && ready_out. ready_out is combinational and
// only ever high in ROW_A with an empty hold register, so a pixel offered while
// ready_out is low must be held by the producer. The output side has no
// back-pressure: pxl_out is meaningful on every cycle where valid_out is high.
module conv_upsample_2x_stream #(
    parameter int DATA_WIDTH    = 32,
    parameter int IMAGE_WIDTH   = 153,
    parameter int IMAGE_HEIGHT  = 153,
    parameter int COL_CNT_WIDTH = $clog2(2*IMAGE_WIDTH),
    parameter int ROW_CNT_WIDTH = $clog2(IMAGE_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done,
    output logic                  state_dbg
);

    // A single-row frame would give a zero-width row counter; keep at least one bit.
    localparam int RW = (ROW_CNT_WIDTH < 1) ? 1 : ROW_CNT_WIDTH;
    // Line buffer address width (at least one bit for a one-pixel row).
    localparam int AW = (IMAGE_WIDTH < 2) ? 1 : $clog2(IMAGE_WIDTH);

    localparam logic [COL_CNT_WIDTH-1:0] LAST_COL = COL_CNT_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [COL_CNT_WIDTH-1:0] LAST_R   = COL_CNT_WIDTH'(2*IMAGE_WIDTH - 1);
    localparam logic [COL_CNT_WIDTH-1:0] ONE_C    = COL_CNT_WIDTH'(1);
    localparam logic [RW-1:0]            LAST_ROW = RW'(IMAGE_HEIGHT - 1);
    localparam logic [RW-1:0]            ONE_R    = RW'(1);

    typedef enum logic {
        ROW_A = 1'b0,
        ROW_B = 1'b1
    } state_t;

    state_t                  state;
    logic [COL_CNT_WIDTH-1:0] col;
    logic [COL_CNT_WIDTH-1:0] r;
    logic [RW-1:0]            row;
    logic [DATA_WIDTH-1:0]    hold_data;
    logic                     hold_full;  // second copy of hold_data still owed
    logic                     row_end;    // hold_data is the last pixel of the row
    logic [DATA_WIDTH-1:0]    line_buf [IMAGE_WIDTH];
    logic [DATA_WIDTH-1:0]    rd_data;
    logic [AW-1:0]            rd_addr;
    logic                     accept;

    assign ready_out = (state == ROW_A) && !hold_full;
    assign accept    = valid_in && ready_out;
    assign state_dbg = (state == ROW_B);

    // Replay address runs one word ahead of the output so the registered read
    // lands exactly when needed; word 0 is prefetched while still in ROW_A.
    always_comb begin
        rd_addr = '0;
        if (state == ROW_B && r != LAST_R) begin
            rd_addr = AW'((r + ONE_C) >> 1);
        end
    end

    // Line buffer: written on accept, read through a register; never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_buf[col[AW-1:0]] <= pxl_in;
        end
        rd_data <= line_buf[rd_addr];
    end

    // Row FSM, counters and registered output stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ROW_A;
            col        <= '0;
            r          <= '0;
            row        <= '0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            row_end    <= 1'b0;
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ROW_A: begin
                    if (hold_full) begin
                        pxl_out   <= hold_data;
                        valid_out <= 1'b1;
                        hold_full <= 1'b0;
                        if (row_end) begin
                            state   <= ROW_B;
                            r       <= '0;
                            col     <= '0;
                            row_end <= 1'b0;
                        end
                    end else if (accept) begin
                        pxl_out   <= pxl_in;
                        valid_out <= 1'b1;
                        hold_data <= pxl_in;
                        hold_full <= 1'b1;
                        if (col == LAST_COL) begin
                            row_end <= 1'b1;
                        end else begin
                            col <= col + ONE_C;
                        end
                    end else begin
                        valid_out <= 1'b0;
                    end
                end
                ROW_B: begin
                    pxl_out   <= rd_data;
                    valid_out <= 1'b1;
                    if (r == LAST_R) begin
                        state      <= ROW_A;
                        r          <= '0;
                        frame_done <= (row == LAST_ROW);
                        row        <= (row == LAST_ROW) ? '0 : row + ONE_R;
                    end else begin
                        r <= r + ONE_C;
                    end
                end
                default: state <= ROW_A;
            endcase
        end
    end

endmodule
